// File: rtl/bitonic_sort_scheduler_pkg.sv
// Shared FSM encodings and the pad-value helper used by the scheduler and its
// unload serializer.
package bitonic_sort_scheduler_pkg;

  localparam int MAX_DATA_WIDTH = 256;

  typedef enum logic {G_FILL, G_FULL} gather_state_t;
  typedef enum logic {S_IDLE, S_BUSY} sort_state_t;
  typedef enum logic {U_IDLE, U_DRAIN} unload_state_t;

  // Pad is the extreme value in the sort direction, so pads always land after real data.
  function automatic logic [MAX_DATA_WIDTH-1:0] pad_value(input int width, input bit is_signed,
                                                          input bit ascending);
    logic [MAX_DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < width) v[i] = ascending;
    end
    if (is_signed) v[width-1] = ~v[width-1];
    return v;
  endfunction

endpackage

// File: rtl/bitonic_sort_scheduler_unload.sv
// Holds one sorted job and hands its real elements out one per ready/valid
// transfer; pad slots beyond the recorded count are never presented.
module sort_unload_serializer #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    load,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] load_data,
  input  logic [LOG_INPUT_NUM:0]                  load_count,
  input  logic                                    out_ready,
  output logic                                    out_valid,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic                                    out_last,
  output logic                                    draining
);
  import bitonic_sort_scheduler_pkg::*;

  localparam int N = 2**LOG_INPUT_NUM;
  localparam logic [LOG_INPUT_NUM-1:0] IDX_ONE = LOG_INPUT_NUM'(1);
  localparam logic [LOG_INPUT_NUM:0]   CNT_ONE = (LOG_INPUT_NUM+1)'(1);

  unload_state_t                 state_q, state_d;
  logic [LOG_INPUT_NUM-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH*N-1:0]       buf_q, buf_d;
  logic [LOG_INPUT_NUM:0]        count_q, count_d;
  logic                          xfer;

  assign out_valid = (state_q == U_DRAIN);
  assign draining  = (state_q == U_DRAIN);
  assign out_last  = (state_q == U_DRAIN) && ({1'b0, idx_q} == (count_q - CNT_ONE));
  assign xfer      = out_valid && out_ready;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == LOG_INPUT_NUM'(k)) out_data = buf_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A load only arrives while idle, so it never competes with a drain transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    count_d = count_q;
    if (load) begin
      state_d = U_DRAIN;
      idx_d   = '0;
      buf_d   = load_data;
      count_d = load_count;
    end else if (xfer) begin
      if (out_last) begin
        state_d = U_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= U_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q   <= buf_d;
    count_q <= count_d;
  end

endmodule

// File: rtl/bitonic_sort_scheduler.sv
// Gathers streamed elements into padded jobs, issues them to an external bitonic
// sorter and serializes the sorted result; the next job gathers while one is in flight.
module bitonic_sort_scheduler #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int SIGNED        = 0,
  parameter int ASCENDING     = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_WIDTH-1:0]                   in_data,
  input  logic                                    in_last,
  output logic                                    sort_x_valid,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] sort_x,
  input  logic                                    sort_y_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] sort_y,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    err_spurious
);
  import bitonic_sort_scheduler_pkg::*;

  localparam int N  = 2**LOG_INPUT_NUM;
  localparam int CW = LOG_INPUT_NUM + 1;
  localparam logic [LOG_INPUT_NUM-1:0]  IDX_ONE  = LOG_INPUT_NUM'(1);
  localparam logic [CW-1:0]             CNT_ONE  = CW'(1);
  localparam logic [MAX_DATA_WIDTH-1:0] PAD_FULL = pad_value(DATA_WIDTH, SIGNED != 0, ASCENDING != 0);
  localparam logic [DATA_WIDTH-1:0]     PAD      = PAD_FULL[DATA_WIDTH-1:0];

  gather_state_t            gather_q, gather_d;
  sort_state_t              sort_q, sort_d;
  logic [LOG_INPUT_NUM-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH*N-1:0]  gbuf_q, gbuf_d;
  logic [CW-1:0]            job_count_q, job_count_d;
  logic [CW-1:0]            flight_count_q, flight_count_d;
  logic                     err_q, err_d;
  logic                     unload_busy;
  logic                     in_xfer;
  logic                     issue;
  logic                     complete;

  assign in_ready     = (gather_q == G_FILL);
  assign in_xfer      = in_valid && in_ready;
  // Unload state is the registered one, so an issue lands the cycle after the final drain.
  assign issue        = (gather_q == G_FULL) && (sort_q == S_IDLE) && !unload_busy;
  assign complete     = (sort_q == S_BUSY) && sort_y_valid;
  assign sort_x_valid = issue;
  assign sort_x       = gbuf_q;
  assign err_spurious = err_q;
  assign busy         = (gather_q != G_FILL) || (cnt_q != '0) || (sort_q == S_BUSY) || unload_busy;

  always_comb begin
    gather_d       = gather_q;
    sort_d         = sort_q;
    cnt_d          = cnt_q;
    gbuf_d         = gbuf_q;
    job_count_d    = job_count_q;
    flight_count_d = flight_count_q;
    err_d          = err_q;
    if (in_xfer) begin
      for (int k = 0; k < N; k++) begin
        if (cnt_q == LOG_INPUT_NUM'(k)) begin
          gbuf_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
        end else if (in_last && (LOG_INPUT_NUM'(k) > cnt_q)) begin
          gbuf_d[k*DATA_WIDTH +: DATA_WIDTH] = PAD;
        end
      end
      cnt_d       = cnt_q + IDX_ONE;
      job_count_d = {1'b0, cnt_q} + CNT_ONE;
      if ((&cnt_q) || in_last) gather_d = G_FULL;
    end
    if (issue) begin
      gather_d       = G_FILL;
      cnt_d          = '0;
      sort_d         = S_BUSY;
      flight_count_d = job_count_q;
    end
    if (complete) sort_d = S_IDLE;
    if (sort_y_valid && (sort_q == S_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gather_q <= G_FILL;
      sort_q   <= S_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      gather_q <= gather_d;
      sort_q   <= sort_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    gbuf_q         <= gbuf_d;
    job_count_q    <= job_count_d;
    flight_count_q <= flight_count_d;
  end

  sort_unload_serializer #(
    .LOG_INPUT_NUM (LOG_INPUT_NUM),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_unload (
    .clk        (clk),
    .rst        (rst),
    .load       (complete),
    .load_data  (sort_y),
    .load_count (flight_count_q),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .draining   (unload_busy)
  );

endmodule
